// File: rtl/reversible_pipelined_adder_if.sv
// Operand/result bundle for reversible_pipelined_adder.
// Both sides use valid/ready: a beat moves on the rising clk edge where valid && ready are both 1.
// The sender holds valid and its payload until that edge. ready never depends on valid in the same cycle.
interface reversible_pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, op, cin, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, op, cin, a, b, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/reversible_pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract built from 4-bit reversible (Peres-gate) slices.
// An entry register holds the preprocessed operands, and one register stage follows per nibble.
module reversible_pipelined_adder #(
  parameter int WIDTH = 16
) (
  input logic                        clk,
  input logic                        rst_n,
  reversible_pipelined_adder_if.slave bus
);
  localparam int NSLICE = WIDTH / 4;

  // Ripple of four Peres full adders. Returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] rev_nibble_add(input logic [3:0] x, input logic [3:0] y,
                                                input logic ci);
    logic [3:0] s;
    logic       c;
    logic       p;
    c = ci;
    for (int i = 0; i < 4; i++) begin
      p    = x[i] ^ y[i];
      s[i] = p ^ c;
      c    = (x[i] & y[i]) ^ (c & p);
    end
    return {c, s};
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_pa;
  logic [WIDTH-1:0] w_pb;
  logic             w_pc;

  logic             r_ev;
  logic [WIDTH-1:0] r_ea;
  logic [WIDTH-1:0] r_eb;
  logic             r_ec;

  logic             r_ovf;
  logic             r_zero;

  // Every stage shifts together whenever the output slot is free or is being taken.
  assign w_adv        = !g_stage[NSLICE-1].r_v || bus.out_ready;
  assign bus.in_ready = w_adv;

  always_comb begin
    w_pa = bus.a;
    w_pb = bus.b;
    w_pc = 1'b0;
    unique case (bus.op)
      2'b01: begin
        w_pb = ~bus.b;
        w_pc = 1'b1;
      end
      2'b10: w_pc = bus.cin;
      2'b11: begin
        w_pa = ~bus.a;
        w_pc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ev <= 1'b0;
      r_ea <= '0;
      r_eb <= '0;
      r_ec <= 1'b0;
    end else if (w_adv) begin
      r_ev <= bus.in_valid;
      if (bus.in_valid) begin
        r_ea <= w_pa;
        r_eb <= w_pb;
        r_ec <= w_pc;
      end
    end
  end

  for (genvar k = 0; k < NSLICE; k++) begin : g_stage
    // Operand bits that are still unconsumed at the input of stage k.
    localparam int SW = WIDTH - 4 * k;

    logic [SW-1:0]    w_in_a;
    logic [SW-1:0]    w_in_b;
    logic             w_in_c;
    logic             w_in_v;
    logic [4:0]       w_add;
    logic [4*k+3:0]   w_nxt_s;

    logic             r_v;
    logic             r_c;
    logic [4*k+3:0]   r_s;

    if (k == 0) begin : g_src
      assign w_in_a  = r_ea;
      assign w_in_b  = r_eb;
      assign w_in_c  = r_ec;
      assign w_in_v  = r_ev;
      assign w_nxt_s = w_add[3:0];
    end else begin : g_src
      assign w_in_a  = g_stage[k-1].g_fwd.r_a;
      assign w_in_b  = g_stage[k-1].g_fwd.r_b;
      assign w_in_c  = g_stage[k-1].r_c;
      assign w_in_v  = g_stage[k-1].r_v;
      assign w_nxt_s = {w_add[3:0], g_stage[k-1].r_s};
    end

    assign w_add = rev_nibble_add(w_in_a[3:0], w_in_b[3:0], w_in_c);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_in_v;
        if (w_in_v) begin
          r_c <= w_add[4];
          r_s <= w_nxt_s;
        end
      end
    end

    if (k < NSLICE - 1) begin : g_fwd
      // Upper operand nibbles ride along, shrinking by one nibble per stage.
      logic [SW-5:0] r_a;
      logic [SW-5:0] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_in_v) begin
          r_a <= w_in_a[SW-1:4];
          r_b <= w_in_b[SW-1:4];
        end
      end
    end else begin : g_last
      logic w_c_msb;

      // The carry into the MSB is recovered from the MSB sum bit and its operand bits.
      assign w_c_msb = w_add[3] ^ w_in_a[3] ^ w_in_b[3];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_adv && w_in_v) begin
          r_ovf  <= w_add[4] ^ w_c_msb;
          r_zero <= (w_nxt_s == '0);
        end
      end
    end
  end

  assign bus.out_valid = g_stage[NSLICE-1].r_v;
  assign bus.sum       = g_stage[NSLICE-1].r_s;
  assign bus.cout      = g_stage[NSLICE-1].r_c;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_reversible_pipelined_adder.sv
// Bench for reversible_pipelined_adder: WIDTH=16 main instance, plus WIDTH=8 and WIDTH=32 instances.
module tb_reversible_pipelined_adder;
  localparam int W  = 16;
  localparam int NS = W / 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  reversible_pipelined_adder_if #(.WIDTH(16)) bus16 ();
  reversible_pipelined_adder_if #(.WIDTH(8))  bus8 ();
  reversible_pipelined_adder_if #(.WIDTH(32)) bus32 ();

  reversible_pipelined_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  reversible_pipelined_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  reversible_pipelined_adder #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W+2:0] exp_q[$];
  int           ret_q[$];
  bit           rec = 1'b0;
  bit           stall_pending = 1'b0;
  logic [W+2:0] held;
  logic [W+2:0] cur16;

  assign cur16 = {bus16.cout, bus16.ovf, bus16.zero, bus16.sum};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {cout, ovf, zero, sum} straight from the arithmetic meaning of each op.
  function automatic logic [W+2:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic ci);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    case (op)
      2'b00: begin
        full = {1'b0, a} + {1'b0, b};
        s = full[W-1:0]; co = full[W];
        ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      2'b01: begin
        s = a - b; co = (a >= b);
        ov = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end
      2'b10: begin
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        s = full[W-1:0]; co = full[W];
        ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      default: begin
        s = b - a; co = (b >= a);
        ov = (a[W-1] != b[W-1]) && (s[W-1] != b[W-1]);
      end
    endcase
    return {co, ov, (s == '0), s};
  endfunction

  function automatic logic [W-1:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'hFFFF;
      1: return 16'h0000;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge rst_n) begin
    exp_q.delete();
    stall_pending = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_rule", bus16.in_ready, !bus16.out_valid || bus16.out_ready);
      if (stall_pending) chk("stall_hold", {bus16.out_valid, cur16}, {1'b1, held});
      stall_pending = bus16.out_valid && !bus16.out_ready;
      held = cur16;
      if (bus16.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("orphan_result", bus16.out_valid, 1'b0);
        end else if (bus16.out_ready) begin
          chk("result", cur16, exp_q.pop_front());
          if (rec) ret_q.push_back(cycle);
        end
      end
      if (bus16.in_valid && bus16.in_ready)
        exp_q.push_back(model(bus16.op, bus16.a, bus16.b, bus16.cin));
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci);
    int guard;
    guard = 0;
    bus16.in_valid = 1'b1;
    bus16.op = op; bus16.a = a; bus16.b = b; bus16.cin = ci;
    @(negedge clk);
    while (!bus16.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 50 cycles");
    end
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || bus16.out_valid) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
    end
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic ci, input logic [W+2:0] lit);
    int lat;
    lat = 0;
    chk({name, "_model"}, model(op, a, b, ci), lit);
    send(op, a, b, ci);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus16.out_valid) begin
        lat = k;
        break;
      end
    end
    chk({name, "_latency"}, lat, NS);
    chk({name, "_value"}, cur16, lit);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    int   filled;
    int   lat8, lat32;
    logic [7:0]  s8;
    logic [31:0] s32;
    logic        c8, c32;

    bus16.in_valid = 0; bus16.op = 0; bus16.cin = 0; bus16.a = 0; bus16.b = 0; bus16.out_ready = 1;
    bus8.in_valid  = 0; bus8.op  = 0; bus8.cin  = 0; bus8.a  = 0; bus8.b  = 0; bus8.out_ready  = 1;
    bus32.in_valid = 0; bus32.op = 0; bus32.cin = 0; bus32.a = 0; bus32.b = 0; bus32.out_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {bus16.out_valid, cur16}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", bus16.in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed vectors with literal expectations.
    directed("add_basic", 2'b00, 16'h1234, 16'h0FF0, 1'b0, 19'h02224);
    directed("sub_zero",  2'b01, 16'h0005, 16'h0005, 1'b0, 19'h50000);
    directed("add_ovf",   2'b00, 16'h7FFF, 16'h0001, 1'b0, 19'h28000);
    directed("addc_wrap", 2'b10, 16'hFFFF, 16'h0000, 1'b1, 19'h50000);
    directed("rsub_ones", 2'b11, 16'h0001, 16'h0000, 1'b0, 19'h0FFFF);
    directed("sub_borrow", 2'b01, 16'h0003, 16'h0005, 1'b0, 19'h0FFFE);
    wait_drain();

    // Back-to-back stream of 8 random beats.
    ret_q.delete();
    rec = 1'b1;
    for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)), rnd16(), rnd16(), 1'($urandom));
    wait_drain();
    rec = 1'b0;
    chk("b2b_count", ret_q.size(), 8);
    for (int i = 1; i < ret_q.size(); i++) chk("b2b_consecutive", ret_q[i] - ret_q[i-1], 1);

    // Backpressure: fill, hold 5 cycles, then drain.
    bus16.out_ready = 1'b0;
    bus16.in_valid = 1'b1;
    bus16.op = 2'($urandom_range(0, 3)); bus16.a = rnd16(); bus16.b = rnd16(); bus16.cin = 1'($urandom);
    filled = 0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (!bus16.in_ready) break;
      @(posedge clk); #1;
      filled++;
      bus16.op = 2'($urandom_range(0, 3)); bus16.a = rnd16(); bus16.b = rnd16(); bus16.cin = 1'($urandom);
    end
    chk("bp_full_in_ready", bus16.in_ready, 1'b0);
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
      bus16.a = rnd16(); bus16.b = rnd16();
      @(negedge clk);
      chk("bp_in_ready", bus16.in_ready, 1'b0);
    end
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    chk("bp_pending", exp_q.size(), filled);
    wait_drain();
    chk("bp_drained", exp_q.size(), 0);

    // Randomised traffic with random backpressure and bubbles.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acc = bus16.in_valid && bus16.in_ready;
      @(posedge clk); #1;
      bus16.out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !bus16.in_valid) begin
        bus16.in_valid = ($urandom_range(0, 3) != 0);
        bus16.op = 2'($urandom_range(0, 3)); bus16.a = rnd16(); bus16.b = rnd16(); bus16.cin = 1'($urandom);
      end
    end
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    wait_drain();

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) send(2'b00, 16'h1111 * 16'(i + 1), 16'h0101, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_clear", {bus16.out_valid, cur16}, '0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("midreset_quiet", bus16.out_valid, 1'b0);
    end
    directed("after_reset", 2'b00, 16'h00FF, 16'h0001, 1'b0, 19'h00100);
    wait_drain();

    // Width sweep: op=11, a=1, b=0 on WIDTH=8 and WIDTH=32.
    bus8.op = 2'b11;  bus8.a = 8'd1;   bus8.b = 8'd0;   bus8.in_valid = 1'b1;
    bus32.op = 2'b11; bus32.a = 32'd1; bus32.b = 32'd0; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus32.in_valid = 1'b0;
    lat8 = 0; lat32 = 0; s8 = '0; s32 = '0; c8 = 1'b1; c32 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (bus8.out_valid && lat8 == 0) begin lat8 = k; s8 = bus8.sum; c8 = bus8.cout; end
      if (bus32.out_valid && lat32 == 0) begin lat32 = k; s32 = bus32.sum; c32 = bus32.cout; end
    end
    chk("w8_latency", lat8, 2);
    chk("w8_sum", s8, 8'hFF);
    chk("w8_cout", c8, 1'b0);
    chk("w32_latency", lat32, 8);
    chk("w32_sum", s32, 32'hFFFF_FFFF);
    chk("w32_cout", c32, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/reversible_pipelined_adder.md
Name: reversible_pipelined_adder

Overview:
- Parametrised, pipelined successor to the combinational 16-bit chained adder.
- Splits a WIDTH-bit add/subtract into WIDTH/4 nibble slices, each built from one 4-bit reversible adder slice, with one register stage per slice.
- Throughput is one operation per cycle, with a valid/ready handshake on both sides, plus carry, overflow and zero flags.
- Sits between the MAC8 operand muxes and the accumulator/output register.

Parameters:
- WIDTH, 16: operand width. Must be a multiple of 4 and at least 8.
- NSLICE, WIDTH/4: number of 4-bit slices. Derived; never overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- op  in  2  operation: 00 A+B; 01 A-B; 10 A+B+cin; 11 B-A.
- cin  in  1  carry-in. Used only when op=10.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of the MSB slice. For subtract ops, 1 means no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  sum equals 0.

Behaviour:
- Reset (rst_n=0, async): all stage valid bits 0. out_valid=0. sum, cout, ovf and zero all 0. in_ready rises combinationally after reset deasserts.
- Accept: a beat is accepted when in_valid && in_ready.
- Advance: `adv = !out_valid || out_ready`. All stages shift together on adv. When adv=0, every stage holds its contents.
- in_ready = adv (combinational from out_valid and out_ready). No combinational path from in_valid to in_ready.
- Operand preprocessing at entry:
  - op 01: B is inverted; carry-in 1.
  - op 11: A is inverted; carry-in 1.
  - op 00: carry-in 0.
  - op 10: carry-in = cin.
- Stage k (0..NSLICE-1):
  - Adds nibble k of the preprocessed operands with the carry registered by stage k-1.
  - Registers the nibble sum, all lower nibble sums, the remaining upper operand nibbles, the carry and the valid bit.
  - Upper operand nibbles are skewed forward unchanged.
- Latency: result is visible with out_valid=1 exactly NSLICE cycles after the accept edge, provided adv stays 1. Default config: 4 cycles.
- Stalls: each cycle with adv=0 adds one cycle of latency. No beat is ever dropped or duplicated.
- Output: sum, cout, ovf and zero are registered in the final stage and stable while out_valid && !out_ready.
  - ovf = carry into the MSB XOR carry out of the MSB, computed on the preprocessed operands.
  - zero = (sum == 0).
- Bubbles: an accept cycle with in_valid=0 inserts a bubble (stage valid 0). Bubbles advance like data. No bubble collapsing.
- Simultaneity: out_ready=1 with a full pipeline accepts a new beat and retires the oldest in the same cycle. Sustained throughput is 1 beat per cycle.
- Wrap-around: arithmetic is modulo 2^WIDTH. Carry beyond the MSB appears only on cout.
- Reset mid-operation: in-flight beats are discarded. No partial result ever appears after reset.
- Inputs a, b, op and cin are sampled only on an accept edge. Changes while in_ready=0 are ignored.

Test Plan:
- Basic add, WIDTH=16: op=00, a=0x1234, b=0x0FF0, single beat. Then out_valid=1 exactly 4 cycles later with sum=0x2224, cout=0, ovf=0, zero=0.
- Subtract, carry and overflow:
  - op=01, a=0x0005, b=0x0005 → sum=0x0000, zero=1, cout=1.
  - op=00, a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, cout=0.
  - op=10, a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, zero=1.
- Back-to-back stream: 8 random beats on consecutive cycles with out_ready=1. Results emerge on 8 consecutive cycles in order, each matching the reference model.
- Backpressure: fill the pipeline, then hold out_ready=0 for 5 cycles. in_ready=0 throughout; sum is stable; nothing is lost. Release out_ready and all beats drain in order.
- Reset mid-flight: 3 beats in flight, then pulse rst_n=0 asynchronously between clock edges. Outputs clear immediately; no result appears afterwards. A fresh beat returns after 4 cycles.
- Parameter sweep: WIDTH=8 and WIDTH=32 with op=11, a=1, b=0 → sum=all ones, cout=0. Latency is 2 and 8 cycles respectively.
